pc_mux: RTL and testbench



---
 rtl/pc_mux_pkg.sv | 14 +
 rtl/pc_mux_mux2.sv | 14 +
 rtl/pc_mux.sv | 56 +++++
 tb/tb_pc_mux.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_mux_pkg.sv
// pc_mux shared types and constants.
// Address width, reset PC default and select encodings for the fetch PC mux.
package pc_mux_pkg;

  localparam int ADDR_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic PC_SEL_SEQ = 1'b0;
  localparam logic PC_SEL_ALT = 1'b1;

endpackage

// File: rtl/pc_mux_mux2.sv
// mux2: width-generic 2:1 multiplexer.
// Ports: d0/d1 data in (W bits), s select (1 picks d1), y data out.
module mux2 #(
  parameter int W = 32
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         s,
  output logic [W-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/pc_mux.sv
// pc_mux: fetch PC source select plus stall-able PC register.
// Ports: clk, rst (sync, active-high), a (seq PC), b (alt PC), sel,
// en (load, 0 = hold), res (comb select), pc_q (registered PC),
// misalign (res not word-aligned). Optional: PC_MUX_ALIGN_CHECK_EN.
module pc_mux
  import pc_mux_pkg::*;
#(
  parameter int              WIDTH    = ADDR_W,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] pc_q,
  output logic             misalign
);

  logic             alt;
  logic [WIDTH-1:0] ld;
  logic [WIDTH-1:0] pc_r;

  assign alt = (sel == PC_SEL_ALT);

  mux2 #(
    .W (WIDTH)
  ) u_mux (
    .d0 (a),
    .d1 (b),
    .s  (alt),
    .y  (res)
  );

`ifdef PC_MUX_ALIGN_CHECK_EN
  // Register only ever holds a word-aligned fetch address.
  assign misalign = (res[1:0] != 2'b00);
  assign ld       = {res[WIDTH-1:2], 2'b00};
`else
  assign misalign = 1'b0;
  assign ld       = res;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (en) begin
      pc_r <= ld;
    end
  end

  assign pc_q = pc_r;

endmodule

// File: tb/tb_pc_mux.sv
// tb_pc_mux: directed self-checking bench for pc_mux.
// Expected values are hand-computed per scenario.
module tb_pc_mux;

`ifdef PC_MUX_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        sel;
  logic        en;
  logic [31:0] res;
  logic [31:0] pc_q;
  logic        misalign;

  int checks;
  int failures;

  pc_mux dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .sel      (sel),
    .en       (en),
    .res      (res),
    .pc_q     (pc_q),
    .misalign (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb();
    logic        em;
    a = 32'h1; b = 32'h2; sel = 1'b0;
    #1;
    checks++;
    if (res !== 32'h1) begin
      failures++;
      $display("FAIL comb_sel0 res=%h want=%h", res, 32'h1);
    end
    em = ALIGN;
    checks++;
    if (misalign !== em) begin
      failures++;
      $display("FAIL comb_mis1 misalign=%b want=%b", misalign, em);
    end
    sel = 1'b1;
    #1;
    checks++;
    if (res !== 32'h2) begin
      failures++;
      $display("FAIL comb_sel1 res=%h want=%h", res, 32'h2);
    end
    b = 32'h8;
    #1;
    checks++;
    if (misalign !== 1'b0) begin
      failures++;
      $display("FAIL comb_mis0 misalign=%b want=0", misalign);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; a = 32'h40; sel = 1'b0;
    tick();
    checks++;
    if (pc_q !== 32'h0) begin
      failures++;
      $display("FAIL reset_pc pc_q=%h want=%h", pc_q, 32'h0);
    end
    checks++;
    if (res !== 32'h40) begin
      failures++;
      $display("FAIL reset_res res=%h want=%h", res, 32'h40);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (pc_q !== 32'h40) begin
      failures++;
      $display("FAIL reset_release pc_q=%h want=%h", pc_q, 32'h40);
    end
  endtask

  task automatic test_toggle();
    logic [31:0] exp_tbl [4];
    exp_tbl[0] = 32'h100; exp_tbl[1] = 32'h200;
    exp_tbl[2] = 32'h100; exp_tbl[3] = 32'h200;
    a = 32'h100; b = 32'h200; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = i[0];
      #1;
      checks++;
      if (res !== exp_tbl[i]) begin
        failures++;
        $display("FAIL toggle_res%0d res=%h want=%h",
                 i, res, exp_tbl[i]);
      end
      tick();
      checks++;
      if (pc_q !== exp_tbl[i]) begin
        failures++;
        $display("FAIL toggle_pc%0d pc_q=%h want=%h",
                 i, pc_q, exp_tbl[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] av [3];
    av[0] = 32'h4; av[1] = 32'h8; av[2] = 32'hC;
    a = 32'h100; sel = 1'b0; en = 1'b1;
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = av[i];
      #1;
      checks++;
      if (res !== av[i]) begin
        failures++;
        $display("FAIL stall_res%0d res=%h want=%h", i, res, av[i]);
      end
      tick();
      checks++;
      if (pc_q !== 32'h100) begin
        failures++;
        $display("FAIL stall_pc%0d pc_q=%h want=%h",
                 i, pc_q, 32'h100);
      end
    end
    sel = 1'b1; b = 32'h300;
    tick();
    checks++;
    if (pc_q !== 32'h100) begin
      failures++;
      $display("FAIL stall_sel pc_q=%h want=%h", pc_q, 32'h100);
    end
    sel = 1'b0; en = 1'b1;
    tick();
    checks++;
    if (pc_q !== 32'hC) begin
      failures++;
      $display("FAIL stall_resume pc_q=%h want=%h", pc_q, 32'hC);
    end
  endtask

  task automatic test_align();
    logic [31:0] ep;
    logic        em;
    ep = ALIGN ? 32'h200 : 32'h203;
    em = ALIGN;
    b = 32'h203; sel = 1'b1; en = 1'b1;
    #1;
    checks++;
    if (misalign !== em) begin
      failures++;
      $display("FAIL align_mis misalign=%b want=%b", misalign, em);
    end
    checks++;
    if (res !== 32'h203) begin
      failures++;
      $display("FAIL align_res res=%h want=%h", res, 32'h203);
    end
    tick();
    checks++;
    if (pc_q !== ep) begin
      failures++;
      $display("FAIL align_pc pc_q=%h want=%h", pc_q, ep);
    end
  endtask

  task automatic test_wide();
    a = 32'hFFFF_FFFC; b = 32'h8000_0000; sel = 1'b0; en = 1'b1;
    tick();
    checks++;
    if (pc_q !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wide_a pc_q=%h want=%h", pc_q, 32'hFFFF_FFFC);
    end
    sel = 1'b1;
    tick();
    checks++;
    if (pc_q !== 32'h8000_0000) begin
      failures++;
      $display("FAIL wide_b pc_q=%h want=%h", pc_q, 32'h8000_0000);
    end
  endtask

  task automatic test_mid_reset();
    a = 32'h500; sel = 1'b0; en = 1'b1; rst = 1'b1;
    tick();
    checks++;
    if (pc_q !== 32'h0) begin
      failures++;
      $display("FAIL midrst_pc pc_q=%h want=%h", pc_q, 32'h0);
    end
    checks++;
    if (res !== 32'h500) begin
      failures++;
      $display("FAIL midrst_res res=%h want=%h", res, 32'h500);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (pc_q !== 32'h500) begin
      failures++;
      $display("FAIL midrst_rel pc_q=%h want=%h", pc_q, 32'h500);
    end
    en = 1'b0; rst = 1'b1;
    tick();
    checks++;
    if (pc_q !== 32'h0) begin
      failures++;
      $display("FAIL rst_stall pc_q=%h want=%h", pc_q, 32'h0);
    end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0; en = 1'b0;
    a = 32'h0; b = 32'h0; sel = 1'b0;
    test_comb();
    test_reset();
    test_toggle();
    test_stall();
    test_align();
    test_wide();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
